ble_k_frac_cfg: RTL and testbench
=================================

// Module: ble_k_frac_cfg
// PURPOSE
//  Parametrised K-input basic logic element: K-LUT, fracturable into two (K-1)-LUTs sharing inputs,
//  one FF with sync set/reset, registered/combinational output select. Config held in an
//  on-block scan chain shifted on the user clock, tracked by a loader FSM with done flag.
//  Instantiated per-BLE inside the CLB; ccff chain daisy-chains BLE to BLE.
// PARAMETERS
//  K         4   LUT input count (3..6); CFG_BITS = 2**K + 3
// PORTS
//  clk        in   1   sole clock; config shift, FSM and FF all on posedge clk
//  reset      in   1   synchronous, active-high; clears config, FSM, FF
//  set        in   1   sync FF set (active only when configured)
//  ble_in     in   K   LUT inputs, ble_in[0] = LSB of truth-table index
//  ble_ce     in   1   FF clock enable (present only with BLE_FF_CE_EN)
//  ccff_en    in   1   shift enable for config chain
//  ccff_head  in   1   config serial in
//  ccff_tail  out  1   config serial out (= cfg[CFG_BITS-1]), to next BLE
//  cfg_done   out  1   high when CFG_BITS bits loaded and ccff_en low
//  ble_out    out  2   [0] main output (comb or FF), [1] secondary combinational output
// BEHAVIOUR
//  Config word cfg[CFG_BITS-1:0]: [2**K-1:0] truth table, [2**K] OUT_SEL, [2**K+1] FF_INIT,
//   [2**K+2] FRAC. Shift: cfg <= {cfg[CFG_BITS-2:0], ccff_head} each clk with ccff_en=1;
//   first bit shifted lands in FRAC.
//  FSM IDLE/SHIFT/DONE, bit counter cnt (clog2(CFG_BITS+1) bits):
//   IDLE : ccff_en -> SHIFT, cnt=1.
//   SHIFT: ccff_en -> cnt++; ccff_en low -> hold (pause, no reset of cnt).
//          on cycle cnt reaches CFG_BITS -> DONE, ff_q <= FF_INIT of new word (next-state cfg).
//   DONE : ccff_en -> SHIFT, cnt=1, cfg_done falls same edge (reconfig restart).
//  cfg_done = (state==DONE), registered.
//  LUT: full = cfg[ble_in]; lo = cfg[{1'b0,ble_in[K-2:0]}]; hi = cfg[{1'b1,ble_in[K-2:0]}].
//   f0 = FRAC ? lo : full; f1 = FRAC ? hi : full.
//  FF (DONE only, else holds): reset>set>ce; reset -> 0, set -> 1, ce -> D=f0.
//   Without macro ce is tied 1.
//  ble_out[0] = OUT_SEL ? ff_q : f0; ble_out[1] = f1; both forced 0 unless cfg_done.
//  Comb path ble_in -> ble_out zero latency; registered path 1 clk.
//  Reset (any state, incl. mid-shift): cfg=0, cnt=0, IDLE, ff_q=0; outputs all 0 next cycle.
//  Overshift: >CFG_BITS shifts in one burst still ends in DONE once ccff_en drops;
//   excess bits pass to ccff_tail (last CFG_BITS bits retained).
//  Simultaneous set&reset: reset wins. ccff_en & reset: reset wins.
// CONFIGURATION
//  BLE_FF_CE_EN defined: ble_ce port exists, FF captures only when ble_ce=1 (set/reset
//   ignore ce). Undefined: no ble_ce port, FF captures every clk in DONE.
// STRUCTURE
//  Package ble_cfg_pkg: cfg_state_e {IDLE,SHIFT,DONE}; functions cfg_bits(K),
//   idx_out_sel(K), idx_ff_init(K), idx_frac(K).
//  Sub-module ble_cfg_chain: shift register + FSM + counter; outputs cfg word, cfg_done,
//   ccff_tail. Top holds LUT muxes, FF, output select.
// TESTING (K=4, CFG_BITS=19)
//  1 Load LUT=16'h8000, OUT_SEL=0, FRAC=0, 19 shifts -> cfg_done=1 after 19th edge;
//    ble_in=4'hF -> ble_out[0]=1 same cycle; ble_in=4'hE -> 0.
//  2 Load OUT_SEL=1, FF_INIT=1, LUT=16'h0000 -> ble_out[0]=1 at cfg_done, 0 one clk later;
//    set=1 -> 1 next clk; set=1&reset=1 -> 0, cfg_done=0.
//  3 FRAC=1, LUT=16'hFF00 -> for all ble_in: ble_out[0]=0, ble_out[1]=1; FRAC=0 same table
//    -> both outputs = ble_in[3].
//  4 Pause ccff_en low 5 clks after bit 10 -> cfg_done only after 19 enabled shifts;
//    resulting cfg matches uninterrupted load.
//  5 reset at bit 7 -> cfg_done=0, ble_out=0, cnt=0; fresh 19-bit load then succeeds.
//  6 Two BLEs chained: shift 38 bits -> both cfg_done, second holds first-shifted 19 bits;
//    BLE_FF_CE_EN build: ble_ce=0 holds ff_q across 4 clks.

Source files
------------

// File: rtl/ble_cfg_pkg.sv
// Shared definitions for the fracturable K-input BLE and its config chain:
// loader state encoding and the bit positions inside the config word.
package ble_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cfg_state_e;

  // Truth table plus OUT_SEL, FF_INIT and FRAC control bits
  function automatic int cfg_bits(input int k);
    return (1 << k) + 3;
  endfunction

  function automatic int idx_out_sel(input int k);
    return (1 << k);
  endfunction

  function automatic int idx_ff_init(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int idx_frac(input int k);
    return (1 << k) + 2;
  endfunction

endpackage

// File: rtl/ble_cfg_chain.sv
// Config scan chain for one BLE: serial shift register, loader FSM and bit
// counter. Raises cfg_done once a full word has been shifted in, and pulses
// ff_load_o on the edge the word becomes valid so the top can preset its FF.
module ble_cfg_chain
  import ble_cfg_pkg::*;
#(
  parameter int K = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ccff_en_i,
  input  logic                   ccff_head_i,
  output logic [cfg_bits(K)-1:0] cfg_o,
  output logic                   cfg_done_o,
  output logic                   ccff_tail_o,
  output logic                   ff_load_o,
  output logic                   ff_init_o
);

  localparam int CB = cfg_bits(K);
  localparam int CW = $clog2(CB + 1);

  cfg_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CB-1:0]   cfg_q, cfg_d;
  logic            full_q, full_d;
  logic            enter_done;

  // Next-state logic. full_q remembers that the current uninterrupted burst
  // already completed a word, so an overshifted burst that stops mid-count
  // still lands in DONE holding the last CB bits.
  always_comb begin
    cfg_d      = ccff_en_i ? {cfg_q[CB-2:0], ccff_head_i} : cfg_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = ccff_en_i ? full_q : 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (ccff_en_i) begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (ccff_en_i) begin
          if (cnt_q == CW'(CB - 1)) begin
            state_d    = DONE;
            cnt_d      = CW'(CB);
            full_d     = 1'b1;
            enter_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (full_q) begin
          state_d    = DONE;
          cnt_d      = CW'(CB);
          enter_done = 1'b1;
        end
      end
      DONE: begin
        if (ccff_en_i) begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Chain registers; reset clears everything, even in the middle of a shift
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cfg_q      <= '0;
      full_q     <= 1'b0;
      cfg_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      full_q     <= full_d;
      cfg_done_o <= (state_d == DONE);
    end
  end

  assign cfg_o       = cfg_q;
  assign ccff_tail_o = cfg_q[CB-1];
  assign ff_load_o   = enter_done & ~reset;
  assign ff_init_o   = cfg_d[idx_ff_init(K)];

endmodule

// File: rtl/ble_k_frac_cfg.sv
// Fracturable K-input basic logic element: one K-LUT or two (K-1)-LUTs with
// shared inputs, an FF with sync set/reset, and a comb/registered output
// select, all configured through a daisy-chained scan chain.
// Optional feature macro BLE_FF_CE_EN adds the ble_ce FF clock-enable port.
module ble_k_frac_cfg
  import ble_cfg_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic [K-1:0] ble_in,
`ifdef BLE_FF_CE_EN
  input  logic         ble_ce,
`endif
  input  logic         ccff_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  output logic         cfg_done,
  output logic [1:0]   ble_out
);

  localparam int TT = 1 << K;
  localparam int CB = cfg_bits(K);

  logic [CB-1:0] cfg;
  logic [TT-1:0] lut;
  logic [K-1:0]  lo_idx, hi_idx;
  logic          full, lo, hi, f0, f1;
  logic          ff_load, ff_init, ce;
  logic          ff_q, ff_d;

  ble_cfg_chain #(.K(K)) u_chain (
    .clk         (clk),
    .reset       (reset),
    .ccff_en_i   (ccff_en),
    .ccff_head_i (ccff_head),
    .cfg_o       (cfg),
    .cfg_done_o  (cfg_done),
    .ccff_tail_o (ccff_tail),
    .ff_load_o   (ff_load),
    .ff_init_o   (ff_init)
  );

`ifdef BLE_FF_CE_EN
  assign ce = ble_ce;
`else
  assign ce = 1'b1;
`endif

  assign lut    = cfg[TT-1:0];
  assign lo_idx = {1'b0, ble_in[K-2:0]};
  assign hi_idx = {1'b1, ble_in[K-2:0]};

  // LUT read: full K-LUT, or lower/upper halves when fractured
  always_comb begin
    full = lut[ble_in];
    lo   = lut[lo_idx];
    hi   = lut[hi_idx];
    f0   = cfg[idx_frac(K)] ? lo : full;
    f1   = cfg[idx_frac(K)] ? hi : full;
  end

  // FF next state: preset from FF_INIT on load, then set > ce while configured
  always_comb begin
    ff_d = ff_q;
    if (ff_load) begin
      ff_d = ff_init;
    end else if (cfg_done) begin
      if (set) begin
        ff_d = 1'b1;
      end else if (ce) begin
        ff_d = f0;
      end
    end
  end

  // BLE flip-flop; reset has priority over set and load
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
    end
  end

  // Outputs are held low until a complete config word is in place
  always_comb begin
    ble_out = 2'b00;
    if (cfg_done) begin
      ble_out[0] = cfg[idx_out_sel(K)] ? ff_q : f0;
      ble_out[1] = f1;
    end
  end

endmodule

// File: tb/tb_ble_k_frac_cfg.sv
// Self-checking bench for ble_k_frac_cfg (K=4): two chained BLEs driven with
// directed and random sequences, compared against a word-level model.
module tb_ble_k_frac_cfg;

  localparam int K  = 4;
  localparam int CB = 19;

  logic         clk = 1'b0;
  logic         reset, set, bleCe, ccffEn, ccffHead;
  logic [K-1:0] bleIn;
  logic         tail0, tail1, done0, done1;
  logic [1:0]   out0, out1;

  int nAsserts = 0;
  int nFail    = 0;

  bit [CB-1:0] mWord [2];
  bit          mDone [2];
  int          mHave [2];
  bit          mFull [2];
  bit          mFf   [2];

  always #5 clk = ~clk;

  ble_k_frac_cfg #(.K(K)) u0 (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .ble_in    (bleIn),
`ifdef BLE_FF_CE_EN
    .ble_ce    (bleCe),
`endif
    .ccff_en   (ccffEn),
    .ccff_head (ccffHead),
    .ccff_tail (tail0),
    .cfg_done  (done0),
    .ble_out   (out0)
  );

  ble_k_frac_cfg #(.K(K)) u1 (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .ble_in    (bleIn),
`ifdef BLE_FF_CE_EN
    .ble_ce    (bleCe),
`endif
    .ccff_en   (ccffEn),
    .ccff_head (tail0),
    .ccff_tail (tail1),
    .cfg_done  (done1),
    .ble_out   (out1)
  );

  // LUT value from the truth table with plain bit arithmetic
  function automatic bit lutFn(bit [CB-1:0] w, bit [3:0] idx, bit upper);
    int pos;
    if (!w[18]) begin
      pos = int'(idx);
    end else begin
      pos = (upper ? 8 : 0) + (int'(idx) % 8);
    end
    return w[pos];
  endfunction

  function automatic bit expOut0(int b);
    if (!mDone[b]) return 1'b0;
    return mWord[b][16] ? mFf[b] : lutFn(mWord[b], bleIn, 1'b0);
  endfunction

  function automatic bit expOut1(int b);
    if (!mDone[b]) return 1'b0;
    return lutFn(mWord[b], bleIn, 1'b1);
  endfunction

  // Model of one clock edge for both BLEs, using the inputs currently applied
  task automatic modelEdge();
    bit heads [2];
    bit ceEff;
`ifdef BLE_FF_CE_EN
    ceEff = bleCe;
`else
    ceEff = bleCe | 1'b1;
`endif
    heads[0] = ccffHead;
    heads[1] = mWord[0][CB-1];
    for (int b = 0; b < 2; b++) begin
      bit [CB-1:0] nw;
      bit enter;
      if (reset) begin
        mWord[b] = '0; mDone[b] = 0; mHave[b] = 0; mFull[b] = 0; mFf[b] = 0;
        continue;
      end
      nw    = ccffEn ? {mWord[b][CB-2:0], heads[b]} : mWord[b];
      enter = 0;
      if (ccffEn) begin
        if (mDone[b]) begin
          mHave[b] = 1;
        end else begin
          mHave[b]++;
          if (mHave[b] == CB) begin
            enter = 1; mFull[b] = 1;
          end
        end
      end else begin
        if (!mDone[b] && mFull[b]) enter = 1;
        mFull[b] = 0;
      end
      if (enter) mFf[b] = nw[17];
      else if (mDone[b]) begin
        if (set) mFf[b] = 1;
        else if (ceEff) mFf[b] = lutFn(mWord[b], bleIn, 1'b0);
      end
      mDone[b] = enter ? 1'b1 : (ccffEn ? 1'b0 : mDone[b]);
      mWord[b] = nw;
    end
  endtask

  task automatic checkBit(string tag, logic obs, logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkBit({tag, ":done0"}, done0, mDone[0]);
    checkBit({tag, ":out0[0]"}, out0[0], expOut0(0));
    checkBit({tag, ":out0[1]"}, out0[1], expOut1(0));
    checkBit({tag, ":tail0"}, tail0, mWord[0][CB-1]);
    checkBit({tag, ":done1"}, done1, mDone[1]);
    checkBit({tag, ":out1[0]"}, out1[0], expOut0(1));
    checkBit({tag, ":out1[1]"}, out1[1], expOut1(1));
    checkBit({tag, ":tail1"}, tail1, mWord[1][CB-1]);
  endtask

  task automatic applyStimulus(bit en, bit head, bit rst, bit st, bit ce, bit [3:0] inp);
    ccffEn = en; ccffHead = head; reset = rst; set = st; bleCe = ce; bleIn = inp;
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(bit [CB-1:0] w, string tag);
    for (int i = CB - 1; i >= 0; i--) begin
      applyStimulus(1, w[i], 0, 0, 1, bleIn);
      if (i <= 1) checkOutput(tag);
    end
    applyStimulus(0, 0, 0, 0, 1, bleIn);
    checkOutput({tag, ":idle"});
  endtask

  task automatic sweepInputs(string tag);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 4'(i));
      checkOutput(tag);
    end
  endtask

  initial begin
    bit [CB-1:0] w, wa;
    reset = 1; set = 0; bleCe = 1; ccffEn = 0; ccffHead = 0; bleIn = '0;
    applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    checkOutput("reset");

    // Single AND-4 function, combinational output
    loadWord({3'b000, 16'h8000}, "t1load");
    applyStimulus(0, 0, 0, 0, 1, 4'hF);
    checkOutput("t1_inF");
    checkBit("t1_inF_const", out0[0], 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 4'hE);
    checkBit("t1_inE_const", out0[0], 1'b0);
    sweepInputs("t1sweep");

    // Registered output with FF_INIT preset, then set and set&reset
    bleIn = 4'h3;
    for (int i = CB - 1; i >= 0; i--) applyStimulus(1, w[i] | (i == 17 || i == 16), 0, 0, 1, 4'h3);
    checkOutput("t2_done");
    checkBit("t2_init_const", out0[0], 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 4'h3);
    checkOutput("t2_capture");
    checkBit("t2_capture_const", out0[0], 1'b0);
    applyStimulus(0, 0, 0, 1, 1, 4'h3);
    checkOutput("t2_set");
    applyStimulus(0, 0, 1, 1, 1, 4'h3);
    checkOutput("t2_setreset");
    checkBit("t2_sr_done_const", done0, 1'b0);

    // Fractured halves, then the same table unfractured
    loadWord({3'b100, 16'hFF00}, "t3frac");
    sweepInputs("t3fracsweep");
    loadWord({3'b000, 16'hFF00}, "t3full");
    sweepInputs("t3fullsweep");

    // Paused load: 10 bits, 5 idle clocks, remaining 9 bits
    w = CB'($urandom);
    for (int i = CB - 1; i >= 9; i--) applyStimulus(1, w[i], 0, 0, 1, bleIn);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(0, 0, 0, 0, 1, 4'($urandom));
      checkOutput("t4pause");
    end
    for (int i = 8; i >= 0; i--) applyStimulus(1, w[i], 0, 0, 1, bleIn);
    checkOutput("t4done");
    checkBit("t4_word", mWord[0] == w, 1'b1);
    sweepInputs("t4sweep");

    // Reset in the middle of a load, then a fresh load
    for (int i = 0; i < 7; i++) applyStimulus(1, 1'($urandom), 0, 0, 1, bleIn);
    applyStimulus(0, 0, 1, 0, 1, bleIn);
    checkOutput("t5reset");
    loadWord(CB'($urandom), "t5load");
    sweepInputs("t5sweep");

    // Overshift burst of 25 bits settles once ccff_en drops
    for (int i = 0; i < 25; i++) applyStimulus(1, 1'($urandom), 0, 0, 1, bleIn);
    checkOutput("ovs_burst");
    applyStimulus(0, 0, 0, 0, 1, bleIn);
    checkOutput("ovs_drop");
    sweepInputs("ovs_sweep");

    // Random FF traffic with registered output
    w = CB'($urandom); w[16] = 1'b1;
    loadWord(w, "ffload");
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 0, 0, ($urandom_range(0, 5) == 0), 1'($urandom), 4'($urandom));
      checkOutput("ffrand");
    end

`ifdef BLE_FF_CE_EN
    // Clock enable low holds the FF across input changes
    applyStimulus(0, 0, 0, 1, 0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 4'($urandom));
      checkOutput("cehold");
      checkBit("cehold_const", out0[0], 1'b1);
    end
`endif

    // Two chained BLEs: 38 bits, second keeps the first 19 shifted
    applyStimulus(0, 0, 1, 0, 1, 0);
    wa = CB'($urandom); wa[16] = 1'b0;
    w  = CB'($urandom);
    for (int i = CB - 1; i >= 0; i--) applyStimulus(1, wa[i], 0, 0, 1, bleIn);
    for (int i = CB - 1; i >= 0; i--) applyStimulus(1, w[i], 0, 0, 1, bleIn);
    checkOutput("t6done");
    applyStimulus(0, 0, 0, 0, 1, bleIn);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 4'(i));
      checkOutput("t6sweep");
      checkBit("t6_second_word", out1[0], lutFn(wa, 4'(i), 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
